// File: rtl/mem_port_arbiter.sv
// Two-master (instruction m0, data m1) arbiter in front of the single-port RAM.
// Round-robin on contention; read data captured in the grant cycle and returned next cycle.
module mem_port_arbiter #(
  parameter int unsigned ADDR_SHIFT = 2,
  parameter bit          RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,

  output logic        port_req_o,
  input  logic        port_gnt_i,
  input  logic        port_rvalid_i,
  output logic [31:0] port_addr_o,
  output logic        port_we_o,
  output logic [31:0] port_wdata_o,
  input  logic [31:0] port_rdata_i,

  output logic        err_o
);

  logic        sel;
  logic        accept;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic [31:0] sel_wdata;

  logic        prio_q, prio_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_id_q, pend_id_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        err_q, err_d;

  // Priority only breaks ties; a lone requester always wins.
  always_comb begin
    if (m0_req_i && m1_req_i) begin
      sel = prio_q;
    end else begin
      sel = m1_req_i;
    end
  end

  always_comb begin
    sel_addr  = sel ? m1_addr_i  : m0_addr_i;
    sel_we    = sel ? m1_we_i    : m0_we_i;
    sel_wdata = sel ? m1_wdata_i : m0_wdata_i;
  end

  assign port_req_o   = m0_req_i | m1_req_i;
  assign port_addr_o  = sel_addr >> ADDR_SHIFT;
  assign port_we_o    = port_req_o & sel_we;
  assign port_wdata_o = sel_wdata;

  assign accept   = port_req_o & port_gnt_i;
  assign m0_gnt_o = accept & ~sel;
  assign m1_gnt_o = accept &  sel;

  always_comb begin
    prio_d       = prio_q;
    pend_valid_d = 1'b0;
    pend_id_d    = pend_id_q;
    rdata_d      = rdata_q;
    if (accept) begin
      prio_d       = ~sel;
      pend_valid_d = 1'b1;
      pend_id_d    = sel;
      rdata_d      = port_rdata_i;
    end
  end

  // Each master's rdata follows rdata_q while it owns the response slot, then holds.
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (!pend_id_q) begin
      m0_rdata_d = rdata_q;
    end else begin
      m1_rdata_d = rdata_q;
    end
  end

  assign m0_rdata_o = pend_id_q ? m0_rdata_q : rdata_q;
  assign m1_rdata_o = pend_id_q ? rdata_q    : m1_rdata_q;

  assign m0_rvalid_o = port_rvalid_i & pend_valid_q & ~pend_id_q;
  assign m1_rvalid_o = port_rvalid_i & pend_valid_q &  pend_id_q;

  // Any disagreement between expected and actual response is a protocol error.
  assign err_d = err_q | (port_rvalid_i ^ pend_valid_q);
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= RESET_PRIO;
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      rdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      rdata_q      <= rdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM environment, round-robin reference model and
// per-master response scoreboards checked by an independent monitor.
module tb_mem_port_arbiter;
  localparam int SHIFT = 2;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_gnt, m0_rv, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_gnt, m1_rv, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        port_req, port_gnt, port_rv, port_we, err;
  logic [31:0] port_addr, port_wdata, port_rdata;

  mem_port_arbiter #(.ADDR_SHIFT(SHIFT), .RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_addr_i(m0_addr),
    .m0_we_i(m0_we), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_addr_i(m1_addr),
    .m1_we_i(m1_we), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
    .port_req_o(port_req), .port_gnt_i(port_gnt), .port_rvalid_i(port_rv),
    .port_addr_o(port_addr), .port_we_o(port_we), .port_wdata_o(port_wdata),
    .port_rdata_i(port_rdata), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM environment: combinational read, write on clock, rvalid one cycle after grant.
  logic [31:0] ram [256];
  logic        env_rv_q, spur, drop;
  assign port_rdata = ram[port_addr[7:0]];
  assign port_rv    = (env_rv_q & ~drop) | spur;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) env_rv_q <= 1'b0;
    else        env_rv_q <= port_req & port_gnt;
  end
  always @(posedge clk) begin
    if (port_req && port_gnt && port_we) ram[port_addr[7:0]] <= port_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; bit wr; } rsp_t;
  rsp_t        q [2][$];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd [2];
  int          last_winner;
  bit          granted [2];
  bit          exp_err;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_winner = 1;  // next tie goes to m0
    q[0].delete();
    q[1].delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    exp_err = 1'b0;
  endtask

  // Called right after inputs are driven for the cycle.
  task automatic step();
    bit          r0, r1, ereq, ewe;
    int          esel, idx;
    logic [31:0] eaddr, ewd;
    rsp_t        r;
    #1;
    r0 = m0_req; r1 = m1_req;
    ereq = r0 | r1;
    if (r0 && r1) esel = (last_winner == 0) ? 1 : 0;
    else          esel = r1 ? 1 : 0;
    eaddr = (esel == 1) ? m1_addr  : m0_addr;
    ewe   = (esel == 1) ? m1_we    : m0_we;
    ewd   = (esel == 1) ? m1_wdata : m0_wdata;
    chk("port_req", 32'(port_req), 32'(ereq));
    chk("port_we", 32'(port_we), 32'(ereq & ewe));
    if (ereq) begin
      chk("port_addr", port_addr, eaddr >> SHIFT);
      chk("port_wdata", port_wdata, ewd);
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(port_gnt && ereq && esel == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(port_gnt && ereq && esel == 1));
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    if (ereq && port_gnt) begin
      idx = int'((eaddr >> SHIFT) & 32'hFF);
      r.data = ref_mem[idx];
      r.cyc  = cyc;
      r.wr   = ewe;
      q[esel].push_back(r);
      if (ewe) ref_mem[idx] = ewd;
      last_winner = esel;
      granted[esel] = 1'b1;
    end
  endtask

  task automatic mon_one(int m, logic rv, logic [31:0] rd);
    bit   exp_rv;
    rsp_t r;
    while (q[m].size() > 0 && q[m][0].cyc + 1 < cyc) void'(q[m].pop_front());
    exp_rv = (q[m].size() > 0) && (q[m][0].cyc + 1 == cyc);
    chk($sformatf("m%0d_rvalid", m), 32'(rv), 32'(exp_rv));
    if (rv && exp_rv) begin
      r = q[m].pop_front();
      last_rd[m] = r.data;
      if (!r.wr) chk($sformatf("m%0d_rdata", m), rd, r.data);
    end else begin
      chk($sformatf("m%0d_rdata_hold", m), rd, last_rd[m]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        mon_one(0, m0_rv, m0_rdata);
        mon_one(1, m1_rv, m1_rdata);
        chk("err", 32'(err), 32'(exp_err));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; port_gnt = 1'b0; spur = 1'b0; drop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(7) == 0) return $urandom;
    return (32'($urandom_range(63)) << 2) | 32'($urandom_range(3));
  endfunction

  task automatic run_random(int n, int req_pct, int gnt_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!m0_req || granted[0]) begin
        m0_req = ($urandom_range(99) < req_pct);
        m0_addr = rnd_addr(); m0_we = ($urandom_range(3) == 0); m0_wdata = $urandom;
      end
      if (!m1_req || granted[1]) begin
        m1_req = ($urandom_range(99) < req_pct);
        m1_addr = rnd_addr(); m1_we = ($urandom_range(2) == 0); m1_wdata = $urandom;
      end
      port_gnt = ($urandom_range(99) < gnt_pct);
      step();
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0; port_gnt = 1'b1;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wdata = '0;
    port_gnt = 1'b0; spur = 1'b0; drop = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hC0DE_0000 + 32'(i * 7);
      ref_mem[i] = 32'hC0DE_0000 + 32'(i * 7);
    end
    ram[4] = 32'h0000_0005;
    ref_mem[4] = 32'h0000_0005;
    model_reset();
    do_reset();
    idle(2);

    // Single read on m0: addr 0x10 -> word 4
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h10; m0_we = 1'b0; port_gnt = 1'b1;
    step();
    chk("single_read_addr", port_addr, 32'd4);
    idle(2);

    // m1 write then read of word 0
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 32'h0; m1_we = 1'b1; m1_wdata = 32'hDEAD_BEEF; port_gnt = 1'b1;
    step();
    @(negedge clk);
    m1_we = 1'b0;
    step();
    idle(2);

    // Continuous contention from reset, then back-to-back random traffic
    do_reset();
    run_random(10, 100, 100);
    idle(2);
    run_random(1500, 70, 75);
    idle(2);

    // Spurious rvalid with nothing pending
    @(negedge clk);
    spur = 1'b1;
    step();
    @(negedge clk);
    spur = 1'b0; exp_err = 1'b1;
    step();
    idle(3);

    // Reset in the cycle after a grant: no rvalid, prio back to m0
    do_reset();
    idle(1);
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h20; m0_we = 1'b0; port_gnt = 1'b1;
    step();
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h40; m1_req = 1'b1; m1_addr = 32'h44; m1_we = 1'b0;
    port_gnt = 1'b1;
    step();
    chk("tie_after_reset_m0", 32'(m0_gnt), 32'd1);
    idle(2);

    // Dropped response: grant without a following rvalid
    do_reset();
    @(negedge clk);
    m1_req = 1'b1; m1_addr = 32'h18; m1_we = 1'b0; port_gnt = 1'b1;
    step();
    @(negedge clk);
    m1_req = 1'b0; drop = 1'b1;
    if (q[1].size() > 0) last_rd[1] = q[1].pop_front().data;
    step();
    @(negedge clk);
    drop = 1'b0; exp_err = 1'b1;
    step();
    idle(2);

    chk("queues_empty", 32'(q[0].size() + q[1].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-master to one-slave arbiter that sits directly upstream of the single-port program/data RAM.
- Merges the core instruction port (m0) and data port (m1) onto the RAM's req/gnt/rvalid port.
- Converts master byte addresses to RAM word indices.
- Captures RAM read data in the grant cycle, because the RAM drives rdata combinationally from the current address, then returns it to the correct master with rvalid.

Parameters:
- ADDR_SHIFT, 2, right shift applied to master byte address to form RAM word index.
- RESET_PRIO, 0, master holding priority out of reset (0 = m0, 1 = m1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- m0_req_i  input  1  instruction master request
- m0_gnt_o  output  1  instruction master grant
- m0_rvalid_o  output  1  instruction response valid
- m0_addr_i  input  32  instruction byte address
- m0_we_i  input  1  instruction write enable (normally 0)
- m0_wdata_i  input  32  instruction write data
- m0_rdata_o  output  32  instruction read data
- m1_req_i, m1_gnt_o, m1_rvalid_o, m1_addr_i, m1_we_i, m1_wdata_i, m1_rdata_o: same as m0, for the data master.
- port_req_o  output  1  request to RAM
- port_gnt_i  input  1  RAM grant
- port_rvalid_i  input  1  RAM response valid (one cycle after gnt)
- port_addr_o  output  32  RAM word index
- port_we_o  output  1  RAM write enable
- port_wdata_o  output  32  RAM write data
- port_rdata_i  input  32  RAM read data (combinational on port_addr_o)
- err_o  output  1  sticky protocol error

Behaviour:
- Reset values:
  - prio = RESET_PRIO.
  - pend_valid = 0, pend_id = 0, rdata_q = 0.
  - All mX_rvalid_o = 0, err_o = 0.
  - mX_rdata_o = 0.
- Arbitration (combinational, same cycle):
  - Only m0_req_i set: sel = 0.
  - Only m1_req_i set: sel = 1.
  - Both set: sel = prio.
  - Neither set: port_req_o = 0 and port_we_o = 0.
- Slave-side outputs:
  - port_req_o = m0_req_i | m1_req_i.
  - port_addr_o = sel master addr >> ADDR_SHIFT, zero-extended.
  - port_we_o and port_wdata_o come from the selected master.
- Master grants:
  - mX_gnt_o = port_gnt_i & port_req_o & (sel == X).
  - Never both high in the same cycle.
  - Loser gnt = 0. Loser must hold req/addr/we/wdata stable until granted.
- Priority update: on each accepted transfer (port_req_o & port_gnt_i), prio <= ~sel. This gives round-robin; it only matters when both masters request.
- Response tracking:
  - On an accepted transfer: pend_valid <= 1, pend_id <= sel, rdata_q <= port_rdata_i (captured in the grant cycle).
  - Otherwise pend_valid <= 0.
- Response return:
  - mX_rvalid_o = port_rvalid_i & pend_valid & (pend_id == X). Combinational from pend_* and port_rvalid_i.
  - mX_rdata_o = rdata_q when pend_id == X, else hold the last value.
  - Write transfers also produce rvalid; the rdata value returned for a write is don't-care to the master.
- Latency and throughput:
  - Grant in the request cycle; rvalid and rdata at cycle +1.
  - Back-to-back grants every cycle are supported.
  - Alternating grants when both masters request continuously: 1 transfer/cycle total, 1 per 2 cycles each.
- Protocol error:
  - port_rvalid_i high with pend_valid = 0: err_o <= 1 (sticky until reset). No master rvalid is asserted for that cycle.
  - pend_valid = 1 with port_rvalid_i = 0: response dropped, err_o <= 1.
- Reset mid-operation:
  - Pending response discarded; no rvalid after reset release.
  - prio returns to RESET_PRIO.
- Addresses whose index exceeds RAM depth are passed unchecked; bounds are the RAM's concern.

Test Plan:
- Single read, m0: m0 req, addr 0x10; RAM mem[4] = 0x0000_0005 -> port_addr_o = 4, m0_gnt_o = 1 same cycle; next cycle m0_rvalid_o = 1, m0_rdata_o = 0x5; m1_rvalid_o stays 0.
- Write then read, m1: m1 write addr 0x0, wdata 0xDEAD_BEEF, then read addr 0x0 -> port_we_o = 1, port_addr_o = 0; two rvalids on m1; second m1_rdata_o = 0xDEAD_BEEF.
- Contention: both request every cycle from reset, RESET_PRIO = 0 -> grants m0, m1, m0, m1; each rvalid goes to the matching master one cycle later with that master's data.
- Simultaneous return and request: m1 rvalid cycle coincides with a new m0 grant -> m1_rvalid_o = 1 and m0_gnt_o = 1 in the same cycle; data not crossed.
- Spurious rvalid: port_rvalid_i pulsed with no prior grant -> no mX_rvalid_o; err_o = 1 and stays 1 until rst_n low.
- Reset mid-op: assert rst_n low in the cycle after a grant -> no rvalid is forwarded; after release, prio = 0, so m0 wins the first tie.
